// File: rtl/snn_frame_scheduler.sv
// Frame scheduler between the SPI front end and the SNN core: FIFO-buffered input frames,
// periodic release with a one-cycle core enable, settle window and result capture.
// Optional per-output spike counters are built when SCHED_SPIKE_COUNT_EN is defined.
module snn_frame_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SPIKE_W       = 24,
  parameter int OUT_W         = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                            system_clock,
  input  logic                            reset,
  input  logic                            run,
  input  logic [7:0]                      interval,
  input  logic                            frame_valid,
  input  logic [SPIKE_W-1:0]              frame_data,
  output logic                            frame_ready,
  input  logic                            flush,
  input  logic                            clear_flags,
  output logic [SPIKE_W-1:0]              snn_input_spikes,
  output logic                            snn_enable,
  input  logic [OUT_W-1:0]                snn_output_spikes,
  output logic                            result_valid,
  output logic [OUT_W-1:0]                result_spikes,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            underrun,
  output logic                            overrun,
  output logic [OUT_W*8-1:0]              out_spike_counts
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [AW-1:0]      PTR_ZERO    = AW'(1'b0);
  localparam logic [AW-1:0]      PTR_ONE     = AW'(1'b1);
  localparam logic [CW-1:0]      CNT_ZERO    = CW'(1'b0);
  localparam logic [CW-1:0]      CNT_ONE     = CW'(1'b1);
  localparam logic [CW-1:0]      CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0]      SET_ZERO    = SW'(1'b0);
  localparam logic [SW-1:0]      SET_ONE     = SW'(1'b1);
  localparam logic [SW-1:0]      SET_LAST    = SW'(SETTLE_CYCLES - 1);
  localparam logic [SPIKE_W-1:0] FRAME_ZERO  = {SPIKE_W{1'b0}};
  localparam logic [OUT_W-1:0]   OUT_ZERO    = {OUT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ISSUE     = 3'd2,
    SETTLE    = 3'd3,
    CAPTURE   = 3'd4
  } state_t;

  state_t               state_r, state_next_s;
  logic [7:0]           period_r, period_last_s;
  logic                 tick_s;
  logic [SW-1:0]        settle_r;
  logic                 issue_s, capture_s;

  logic [SPIKE_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_next_s;
  logic                 empty_s, push_s, pop_s;

  logic                 ready_r;
  logic [SPIKE_W-1:0]   in_spikes_r;
  logic                 enable_r;
  logic                 res_valid_r;
  logic [OUT_W-1:0]     res_spikes_r;
  logic                 underrun_r, overrun_r;

  // An interval of zero behaves as a period of one cycle.
  assign period_last_s = (interval == 8'd0) ? 8'd0 : (interval - 8'd1);
  assign tick_s        = run && (period_r >= period_last_s);

  assign issue_s   = (state_r == WAIT_TICK) && tick_s;
  assign capture_s = (state_r == SETTLE) && (settle_r == SET_LAST);

  assign empty_s = (count_r == CNT_ZERO);
  assign push_s  = frame_valid && ready_r && !flush;
  assign pop_s   = issue_s && !empty_s;

  // Release period counter, held at zero while the scheduler is stopped.
  always_ff @(posedge system_clock) begin
    if (reset || !run) begin
      period_r <= 8'd0;
    end else if (period_r >= period_last_s) begin
      period_r <= 8'd0;
    end else begin
      period_r <= period_r + 8'd1;
    end
  end

  // FSM state register and settle-window counter.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_r  <= IDLE;
      settle_r <= SET_ZERO;
    end else begin
      state_r <= state_next_s;
      if ((state_r == SETTLE) && (state_next_s == SETTLE)) begin
        settle_r <= settle_r + SET_ONE;
      end else begin
        settle_r <= SET_ZERO;
      end
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_next_s = WAIT_TICK;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_TICK: begin
        if (tick_s) begin
          state_next_s = ISSUE;
        end else if (!run) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_TICK;
        end
      end
      ISSUE: begin
        state_next_s = SETTLE;
      end
      SETTLE: begin
        if (settle_r == SET_LAST) begin
          state_next_s = CAPTURE;
        end else begin
          state_next_s = SETTLE;
        end
      end
      CAPTURE: begin
        if (run) begin
          state_next_s = WAIT_TICK;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy; flush dominates any push or pop in the same cycle.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage; entries carry no reset since occupancy gates every read.
  always_ff @(posedge system_clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= frame_data;
    end
  end

  // FIFO pointers and occupancy registers.
  always_ff @(posedge system_clock) begin
    if (reset || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // Core-facing and result outputs plus sticky flags; a flag set beats a clear.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      in_spikes_r  <= FRAME_ZERO;
      enable_r     <= 1'b0;
      res_valid_r  <= 1'b0;
      res_spikes_r <= OUT_ZERO;
      underrun_r   <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      enable_r    <= issue_s;
      res_valid_r <= capture_s;
      if (issue_s) begin
        in_spikes_r <= empty_s ? FRAME_ZERO : mem_r[rd_ptr_r];
      end
      if (capture_s) begin
        res_spikes_r <= snn_output_spikes;
      end
      if (issue_s && empty_s) begin
        underrun_r <= 1'b1;
      end else if (clear_flags) begin
        underrun_r <= 1'b0;
      end
      if (tick_s && (state_r != WAIT_TICK)) begin
        overrun_r <= 1'b1;
      end else if (clear_flags) begin
        overrun_r <= 1'b0;
      end
    end
  end

`ifdef SCHED_SPIKE_COUNT_EN
  logic [OUT_W*8-1:0] spk_cnt_r;

  // Saturating per-output spike counters; an increment coinciding with clear leaves 1.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      spk_cnt_r <= {(OUT_W*8){1'b0}};
    end else begin
      for (int n = 0; n < OUT_W; n++) begin
        if (capture_s && snn_output_spikes[n]) begin
          if (clear_flags) begin
            spk_cnt_r[8*n +: 8] <= 8'd1;
          end else if (spk_cnt_r[8*n +: 8] != 8'hFF) begin
            spk_cnt_r[8*n +: 8] <= spk_cnt_r[8*n +: 8] + 8'd1;
          end
        end else if (clear_flags) begin
          spk_cnt_r[8*n +: 8] <= 8'd0;
        end
      end
    end
  end

  assign out_spike_counts = spk_cnt_r;
`else
  assign out_spike_counts = {(OUT_W*8){1'b0}};
`endif

  assign frame_ready      = ready_r;
  assign fifo_count       = count_r;
  assign snn_input_spikes = in_spikes_r;
  assign snn_enable       = enable_r;
  assign result_valid     = res_valid_r;
  assign result_spikes    = res_spikes_r;
  assign underrun         = underrun_r;
  assign overrun          = overrun_r;

endmodule
